hidden_layer_ctrl: RTL
======================

Name: hidden_layer_ctrl

Overview:
Sequencer for the 30x196 hidden layer. It walks each neuron's weight row and the 196-entry pixel buffer, and issues read addresses to the weight, bias and pixel memories. It runs a single shared MAC, adds the neuron bias, then applies ReLU, scaling and saturation. One 8-bit activation per neuron is streamed to the output-layer buffer. It sits between the preprocessed-image buffer and the output-layer stage, and is started once per image by the top-level FSM.

Parameters:
N_IN, 196, inputs per neuron (pixel buffer depth)
N_NEUR, 30, neurons in the layer
W, 8, weight/bias/pixel/activation width
ACC_W, 24, accumulator width (signed)
SHIFT, 7, fixed-point shift: bias is aligned left by SHIFT; the result is shifted right by SHIFT

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous, active-low reset
start  in  1  one-cycle request to process one image; honoured only in IDLE
busy  out  1  high from the cycle after start is accepted until the done cycle, exclusive
done  out  1  one-cycle pulse when all neurons are written
pixel_addr  out  8  pixel buffer read address (0..N_IN-1)
pixel_data  in  W  unsigned pixel; the memory has 1-cycle read latency
weight_addr  out  13  weight ROM address, neuron*N_IN + j
weight_data  in  W  signed weight; 1-cycle latency
bias_addr  out  5  bias ROM address (neuron index)
bias_data  in  W  signed bias; 1-cycle latency
out_valid  out  1  one-cycle strobe: activation available
out_idx  out  5  neuron index of out_data
out_data  out  W  unsigned activation, 0..2^(W-1)-1

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; busy=0, done=0, out_valid=0; out_idx=0, out_data=0; all address outputs and counters 0; accumulator 0. A reset asserted mid-run aborts immediately. No further out_valid or done is produced.
- States and transitions:
  - IDLE: start=1 -> BIAS; neuron counter n=0, weight address counter=0.
  - BIAS (1 cycle): bias_addr=n -> MAC.
  - MAC (N_IN cycles, j=0..N_IN-1):
    - pixel_addr=j; weight_addr=base+j.
    - Cycle j=0: acc <= sign_ext(bias_data) <<< SHIFT.
    - Cycle j>=1: acc += product(j-1).
    - After j=N_IN-1 -> DRAIN.
  - DRAIN (1 cycle): acc += product(N_IN-1) -> OUT.
  - OUT (1 cycle):
    - out_valid=1, out_idx=n.
    - out_data = min(max(acc,0) >>> SHIFT, 2^(W-1)-1).
    - If n=N_NEUR-1 -> DONE; else n++, base += N_IN -> BIAS.
  - DONE (1 cycle): done=1 -> IDLE.
- Product: zero_ext(pixel_data) to W+1 bits times signed weight_data, giving a signed 2W+1-bit result, sign-extended to ACC_W. The weight address is an incrementing counter; no multiplier is used for addressing.
- Overflow: with defaults, the worst-case |acc| < 2^23, so no wrap is possible. Saturation applies only at the output.
- Timing, with start sampled at edge T=0:
  - BIAS of neuron k occurs in cycle 199k+1.
  - out_valid for neuron k occurs in cycle 199(k+1).
  - The last out_valid is in cycle 5970; done is in cycle 5971.
  - busy is high for cycles 1..5970.
  - Per-neuron period is N_IN+3 cycles.
- start while not IDLE is ignored; it is neither queued nor restarts the run. start in the DONE cycle is also ignored.
- Address outputs hold their last value in IDLE, DONE and OUT. The memories may read freely; their data is ignored outside the MAC and DRAIN states.
- out_data and out_idx hold their values between strobes.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles -> busy=0, done=0, out_valid=0, out_data=0, out_idx=0; start during reset is ignored.
- Bias-only path: all weights 0, bias[n]=n+1 -> 30 strobes with out_data=n+1 and out_idx=n, in cycles 199, 398, ..., 5970; done in cycle 5971.
- ReLU: all weights 0, bias=-5 -> every out_data=0. Separately, pixel[0]=1, weight[n][0]=-128, bias=0 -> out_data=0.
- Arithmetic and saturation:
  - pixel[j]=2, weight[0][j]=1, bias=0 -> acc=392, out_data=3 (392>>7).
  - All pixels 255, weights 127 -> out_data=127 (saturated).
- Address sequencing: monitor weight_addr -> 0..195 for neuron 0 and 196..391 for neuron 1, ending at 5879; pixel_addr cycles 0..195 per neuron.
- Mid-run events: start pulsed at cycle 1000 -> ignored, strobe count stays 30. Then run again and drop reset_n at cycle 3000 -> next cycle state is IDLE, with no further strobes or done. A fresh start then completes normally.

Source files
------------

// File: rtl/hidden_layer_ctrl.sv
// Hidden-layer sequencer: walks 30 neurons x 196 inputs through one shared MAC,
// adds the aligned bias, then applies ReLU, scaling and saturation before
// streaming one 8-bit activation per neuron to the output-layer buffer.
module hidden_layer_ctrl #(
  parameter int N_IN   = 196,
  parameter int N_NEUR = 30,
  parameter int W      = 8,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    pixel_addr,
  input  logic [W-1:0]  pixel_data,
  output logic [12:0]   weight_addr,
  input  logic [W-1:0]  weight_data,
  output logic [4:0]    bias_addr,
  input  logic [W-1:0]  bias_data,
  output logic          out_valid,
  output logic [4:0]    out_idx,
  output logic [W-1:0]  out_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BIAS  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [7:0]       LAST_IN     = 8'(N_IN - 1);
  localparam logic [4:0]       LAST_NEUR   = 5'(N_NEUR - 1);
  localparam logic [12:0]      ROW_STRIDE  = 13'(N_IN);
  localparam logic [W-1:0]     ACT_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACT_MAX_ACC = {{(ACC_W-W){1'b0}}, ACT_MAX};

  logic [2:0]              state;
  logic [4:0]              neuron;
  logic [12:0]             row_base;
  logic signed [ACC_W-1:0] acc;

  logic signed [2*W:0]     pixel_ext;
  logic signed [2*W:0]     weight_ext;
  logic signed [2*W:0]     product;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] bias_init;
  logic [ACC_W-1:0]        sum_bits;
  logic [ACC_W-1:0]        relu_scaled;
  logic [W-1:0]            activation;

  // Status strobes come straight from the state register, so they are glitch-free
  always_comb begin
    busy      = (state == S_BIAS) || (state == S_MAC) ||
                (state == S_DRAIN) || (state == S_OUT);
    done      = (state == S_DONE);
    out_valid = (state == S_OUT);
  end

  // MAC datapath: unsigned pixel times signed weight, then the bias-aligned start
  // value and the ReLU/scale/saturate result of the running sum
  always_comb begin
    pixel_ext   = {{W{1'b0}}, pixel_data};
    weight_ext  = {{(W+1){weight_data[W-1]}}, weight_data};
    product     = pixel_ext * weight_ext;
    acc_sum     = acc + {{(ACC_W-2*W-1){product[2*W]}}, product};
    bias_init   = {{(ACC_W-W-SHIFT){bias_data[W-1]}}, bias_data, {SHIFT{1'b0}}};
    sum_bits    = acc_sum;
    relu_scaled = sum_bits[ACC_W-1] ? '0 : (sum_bits >> SHIFT);
    activation  = (relu_scaled > ACT_MAX_ACC) ? ACT_MAX : relu_scaled[W-1:0];
  end

  // Sequencer: address counters run one cycle ahead of the data they fetch,
  // and DRAIN folds in the last product while latching the activation for OUT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      neuron      <= '0;
      row_base    <= '0;
      acc         <= '0;
      pixel_addr  <= '0;
      weight_addr <= '0;
      bias_addr   <= '0;
      out_idx     <= '0;
      out_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_BIAS;
            neuron    <= '0;
            row_base  <= '0;
            bias_addr <= '0;
          end
        end
        S_BIAS: begin
          state       <= S_MAC;
          pixel_addr  <= '0;
          weight_addr <= row_base;
        end
        S_MAC: begin
          if (pixel_addr == '0) begin
            acc <= bias_init;
          end else begin
            acc <= acc_sum;
          end
          if (pixel_addr == LAST_IN) begin
            state <= S_DRAIN;
          end else begin
            pixel_addr  <= pixel_addr + 8'd1;
            weight_addr <= weight_addr + 13'd1;
          end
        end
        S_DRAIN: begin
          acc      <= acc_sum;
          out_data <= activation;
          out_idx  <= neuron;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (neuron == LAST_NEUR) begin
            state <= S_DONE;
          end else begin
            neuron    <= neuron + 5'd1;
            bias_addr <= neuron + 5'd1;
            row_base  <= row_base + ROW_STRIDE;
            state     <= S_BIAS;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
